// File: rtl/dma_chan_regfile.sv
// DMA channel register file: per-channel mode/address/count plus shared command, request,
// mask and status registers, CPU programming port decode and per-transfer update logic.
module dma_chan_regfile #(
   parameter  int unsigned NCH = 4,
   parameter  int unsigned DW  = 8,
   localparam int unsigned AW  = 2 * DW,
   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int unsigned RAW = $clog2(2 * NCH + 8)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cpu_wr_i,
   input  logic             cpu_rd_i,
   input  logic [RAW-1:0]   cpu_addr_i,
   input  logic [DW-1:0]    cpu_wdata_i,
   output logic [DW-1:0]    cpu_rdata_o,
   input  logic [NCH-1:0]   dreq_i,
   input  logic             upd_valid_i,
   input  logic [CHW-1:0]   upd_ch_i,
   input  logic             eop_i,
   output logic [AW-1:0]    addr_o,
   output logic [NCH-1:0]   tc_o,
   output logic [6*NCH-1:0] mode_o,
   output logic [DW-1:0]    command_o,
   output logic [NCH-1:0]   request_o,
   output logic [NCH-1:0]   mask_o
);

   localparam int unsigned C = 2 * NCH;

   logic [AW-1:0]  base_addr_q [NCH];
   logic [AW-1:0]  base_addr_d [NCH];
   logic [AW-1:0]  cur_addr_q  [NCH];
   logic [AW-1:0]  cur_addr_d  [NCH];
   logic [AW-1:0]  base_cnt_q  [NCH];
   logic [AW-1:0]  base_cnt_d  [NCH];
   logic [AW-1:0]  cur_cnt_q   [NCH];
   logic [AW-1:0]  cur_cnt_d   [NCH];
   logic [5:0]     mode_q      [NCH];
   logic [5:0]     mode_d      [NCH];
   logic [DW-1:0]  command_q, command_d;
   logic [DW-1:0]  rdata_q, rdata_d;
   logic [NCH-1:0] request_q, request_d;
   logic [NCH-1:0] mask_q, mask_d;
   logic [NCH-1:0] tc_flags_q, tc_flags_d;
   logic [NCH-1:0] tc_q, tc_d;
   logic           bp_q, bp_d;

   int unsigned    addr_int;
   logic           chan_hit, ctl_hit, tc_hit;
   logic [2:0]     ctl_idx;
   logic [CHW-1:0] wr_ch;
   logic           wr_bit;
   logic [AW-1:0]  rd_val;

   function automatic logic [AW-1:0] put_byte(input logic [AW-1:0] v, input logic hi,
                                              input logic [DW-1:0] b);
      put_byte = hi ? {b, v[DW-1:0]} : {v[AW-1:DW], b};
   endfunction

   always_comb begin
      addr_int = 32'(cpu_addr_i);
      chan_hit = addr_int < C;
      ctl_hit  = (addr_int >= C) && (addr_int < C + 8);
      ctl_idx  = 3'(addr_int - C);
      wr_ch    = cpu_wdata_i[CHW-1:0];
      wr_bit   = cpu_wdata_i[CHW];
   end

   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         base_addr_d[i] = base_addr_q[i];
         cur_addr_d[i]  = cur_addr_q[i];
         base_cnt_d[i]  = base_cnt_q[i];
         cur_cnt_d[i]   = cur_cnt_q[i];
         mode_d[i]      = mode_q[i];
      end
      command_d  = command_q;
      request_d  = request_q;
      mask_d     = mask_q;
      tc_flags_d = tc_flags_q;
      tc_d       = '0;
      rdata_d    = rdata_q;
      bp_d       = bp_q;
      rd_val     = '0;
      tc_hit     = 1'b0;

      if (cpu_rd_i) begin
         rdata_d = '0;
         if (chan_hit) begin
            for (int unsigned i = 0; i < NCH; i++) begin
               if (addr_int == 2 * i)     rd_val = cur_addr_q[i];
               if (addr_int == 2 * i + 1) rd_val = cur_cnt_q[i];
            end
            rdata_d = bp_q ? rd_val[AW-1:DW] : rd_val[DW-1:0];
            bp_d    = ~bp_q;
         end else if (ctl_hit) begin
            case (ctl_idx)
               3'd0: begin
                  rdata_d    = DW'({dreq_i, tc_flags_q});
                  tc_flags_d = '0;
               end
               3'd7:    rdata_d = DW'(mask_q);
               default: ;
            endcase
         end
      end

      if (cpu_wr_i && ctl_hit) begin
         case (ctl_idx)
            3'd0: command_d = cpu_wdata_i;
            3'd1: if (32'(wr_ch) < NCH) request_d[wr_ch] = wr_bit;
            3'd2: if (32'(wr_ch) < NCH) mask_d[wr_ch] = wr_bit;
            3'd3: if (32'(wr_ch) < NCH) mode_d[wr_ch] = cpu_wdata_i[CHW+5:CHW];
            3'd4: bp_d = 1'b0;
            3'd6: mask_d = '0;
            3'd7: mask_d = cpu_wdata_i[NCH-1:0];
            default: ;
         endcase
      end

      // TC effects land after CPU writes so a same-cycle status read or mask write loses
      if (upd_valid_i) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(upd_ch_i) == i) begin
               tc_hit        = (cur_cnt_q[i] == '0) || eop_i;
               cur_addr_d[i] = mode_q[i][2] ? cur_addr_q[i] - AW'(1) : cur_addr_q[i] + AW'(1);
               cur_cnt_d[i]  = cur_cnt_q[i] - AW'(1);
               if (tc_hit) begin
                  tc_d[i]       = 1'b1;
                  tc_flags_d[i] = 1'b1;
                  request_d[i]  = 1'b0;
                  if (mode_q[i][3]) begin
                     cur_addr_d[i] = base_addr_q[i];
                     cur_cnt_d[i]  = base_cnt_q[i];
                  end else begin
                     mask_d[i] = 1'b1;
                  end
               end
            end
         end
      end

      // CPU channel writes merge into the pre-update value, dropping that register's update
      if (cpu_wr_i && chan_hit) begin
         bp_d = ~bp_q;
         for (int unsigned i = 0; i < NCH; i++) begin
            if (addr_int == 2 * i) begin
               base_addr_d[i] = put_byte(base_addr_q[i], bp_q, cpu_wdata_i);
               cur_addr_d[i]  = put_byte(cur_addr_q[i], bp_q, cpu_wdata_i);
            end
            if (addr_int == 2 * i + 1) begin
               base_cnt_d[i] = put_byte(base_cnt_q[i], bp_q, cpu_wdata_i);
               cur_cnt_d[i]  = put_byte(cur_cnt_q[i], bp_q, cpu_wdata_i);
            end
         end
      end

      if (cpu_wr_i && ctl_hit && (ctl_idx == 3'd5)) begin
         command_d  = '0;
         request_d  = '0;
         tc_flags_d = '0;
         bp_d       = 1'b0;
         mask_d     = '1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            base_addr_q[i] <= '0;
            cur_addr_q[i]  <= '0;
            base_cnt_q[i]  <= '0;
            cur_cnt_q[i]   <= '0;
            mode_q[i]      <= '0;
         end
         command_q  <= '0;
         request_q  <= '0;
         mask_q     <= '1;
         tc_flags_q <= '0;
         tc_q       <= '0;
         rdata_q    <= '0;
         bp_q       <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            base_addr_q[i] <= base_addr_d[i];
            cur_addr_q[i]  <= cur_addr_d[i];
            base_cnt_q[i]  <= base_cnt_d[i];
            cur_cnt_q[i]   <= cur_cnt_d[i];
            mode_q[i]      <= mode_d[i];
         end
         command_q  <= command_d;
         request_q  <= request_d;
         mask_q     <= mask_d;
         tc_flags_q <= tc_flags_d;
         tc_q       <= tc_d;
         rdata_q    <= rdata_d;
         bp_q       <= bp_d;
      end
   end

   always_comb begin
      mode_o = '0;
      addr_o = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         mode_o[6*i +: 6] = mode_q[i];
         if (32'(upd_ch_i) == i) addr_o = cur_addr_q[i];
      end
   end

   assign cpu_rdata_o = rdata_q;
   assign tc_o        = tc_q;
   assign command_o   = command_q;
   assign request_o   = request_q;
   assign mask_o      = mask_q;

endmodule

// File: tb/tb_dma_chan_regfile.sv
// Directed self-checking bench for dma_chan_regfile (NCH=4, DW=8, control base offset 8).
module tb_dma_chan_regfile;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_wr = 1'b0;
   logic        cpu_rd = 1'b0;
   logic [3:0]  cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic [7:0]  cpu_rdata;
   logic [3:0]  dreq = '0;
   logic        upd_valid = 1'b0;
   logic [1:0]  upd_ch = '0;
   logic        eop = 1'b0;
   logic [15:0] addr_o;
   logic [3:0]  tc_o;
   logic [23:0] mode_o;
   logic [7:0]  command_o;
   logic [3:0]  request_o;
   logic [3:0]  mask_o;

   int n_checks = 0;
   int n_fail   = 0;

   dma_chan_regfile #(.NCH(4), .DW(8)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cpu_wr_i    (cpu_wr),
      .cpu_rd_i    (cpu_rd),
      .cpu_addr_i  (cpu_addr),
      .cpu_wdata_i (cpu_wdata),
      .cpu_rdata_o (cpu_rdata),
      .dreq_i      (dreq),
      .upd_valid_i (upd_valid),
      .upd_ch_i    (upd_ch),
      .eop_i       (eop),
      .addr_o      (addr_o),
      .tc_o        (tc_o),
      .mode_o      (mode_o),
      .command_o   (command_o),
      .request_o   (request_o),
      .mask_o      (mask_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
      @(negedge clk);
      cpu_wr = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a);
      @(negedge clk);
      cpu_rd = 1'b1; cpu_addr = a;
      @(negedge clk);
      cpu_rd = 1'b0;
   endtask

   task automatic upd(input logic [1:0] ch, input logic e);
      @(negedge clk);
      upd_valid = 1'b1; upd_ch = ch; eop = e;
      @(negedge clk);
      upd_valid = 1'b0; eop = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mask", mask_o, 32'hF);
      chk("rst_command", command_o, 32'h0);
      chk("rst_request", request_o, 32'h0);
      chk("rst_mode", mode_o, 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_tc", tc_o, 32'h0);

      // Byte pointer
      wr(4'd0, 8'h34);
      wr(4'd0, 8'h12);
      rd(4'd0);
      chk("bp_rd_lo", cpu_rdata, 32'h34);
      rd(4'd0);
      chk("bp_rd_hi", cpu_rdata, 32'h12);
      wr(4'd0, 8'hAA);
      wr(4'd12, 8'h00);
      wr(4'd0, 8'h56);
      upd_ch = 2'd0;
      @(negedge clk);
      chk("bp_clear_addr", addr_o, 32'h1256);
      wr(4'd12, 8'h00);

      // TC without autoinit, channel 1
      wr(4'd3, 8'h02);
      wr(4'd3, 8'h00);
      wr(4'd2, 8'h00);
      wr(4'd2, 8'h10);
      wr(4'd11, 8'h45);
      chk("ch1_mode", mode_o, 32'h000440);
      wr(4'd10, 8'h01);
      chk("ch1_unmask", mask_o, 32'hD);
      wr(4'd9, 8'h05);
      chk("ch1_request", request_o, 32'h2);
      upd(2'd1, 1'b0);
      chk("ch1_upd1_tc", tc_o, 32'h0);
      upd(2'd1, 1'b0);
      chk("ch1_upd2_tc", tc_o, 32'h0);
      upd(2'd1, 1'b0);
      chk("ch1_tc_pulse", tc_o, 32'h2);
      chk("ch1_tc_req_clr", request_o, 32'h0);
      chk("ch1_tc_mask", mask_o, 32'hF);
      @(negedge clk);
      chk("ch1_tc_one_cycle", tc_o, 32'h0);
      chk("ch1_addr", addr_o, 32'h1003);
      rd(4'd3);
      chk("ch1_cnt_lo", cpu_rdata, 32'hFF);
      rd(4'd3);
      chk("ch1_cnt_hi", cpu_rdata, 32'hFF);
      dreq = 4'b1000;
      rd(4'd8);
      chk("status_tc1", cpu_rdata, 32'h82);
      rd(4'd8);
      chk("status_cleared", cpu_rdata, 32'h80);
      dreq = 4'b0000;

      // Autoinit + decrement, channel 2
      wr(4'd4, 8'h00);
      wr(4'd4, 8'h20);
      wr(4'd5, 8'h01);
      wr(4'd5, 8'h00);
      wr(4'd11, 8'hB6);
      chk("ch2_mode", mode_o, 32'h02D440);
      wr(4'd10, 8'h02);
      chk("ch2_unmask", mask_o, 32'hB);
      upd(2'd2, 1'b0);
      chk("ch2_dec_tc", tc_o, 32'h0);
      chk("ch2_dec_addr", addr_o, 32'h1FFF);
      upd(2'd2, 1'b0);
      chk("ch2_tc_pulse", tc_o, 32'h4);
      chk("ch2_reload_addr", addr_o, 32'h2000);
      chk("ch2_mask_kept", mask_o, 32'hB);
      rd(4'd5);
      chk("ch2_reload_cnt_lo", cpu_rdata, 32'h01);
      rd(4'd5);
      chk("ch2_reload_cnt_hi", cpu_rdata, 32'h00);

      // Status read in the same cycle as a TC (eop-forced on ch2)
      @(negedge clk);
      cpu_rd = 1'b1; cpu_addr = 4'd8;
      upd_valid = 1'b1; upd_ch = 2'd2; eop = 1'b1;
      @(negedge clk);
      cpu_rd = 1'b0; upd_valid = 1'b0; eop = 1'b0;
      chk("rdtc_status", cpu_rdata, 32'h04);
      chk("rdtc_pulse", tc_o, 32'h4);
      rd(4'd8);
      chk("rdtc_flag_kept", cpu_rdata, 32'h04);
      rd(4'd8);
      chk("rdtc_flag_clr", cpu_rdata, 32'h00);

      // CPU write to ch0 low address byte during ch0 update (count 0 -> TC)
      @(negedge clk);
      cpu_wr = 1'b1; cpu_addr = 4'd0; cpu_wdata = 8'h55;
      upd_valid = 1'b1; upd_ch = 2'd0;
      @(negedge clk);
      cpu_wr = 1'b0; upd_valid = 1'b0;
      chk("wrconf_tc", tc_o, 32'h1);
      chk("wrconf_addr", addr_o, 32'h1255);
      wr(4'd12, 8'h00);
      rd(4'd0);
      chk("wrconf_lo", cpu_rdata, 32'h55);
      rd(4'd0);
      chk("wrconf_hi", cpu_rdata, 32'h12);
      rd(4'd8);
      chk("wrconf_status", cpu_rdata, 32'h01);

      // Write-all-mask, command, request and master clear
      wr(4'd15, 8'h05);
      rd(4'd15);
      chk("mask_all_rd", cpu_rdata, 32'h05);
      wr(4'd8, 8'hA5);
      chk("command", command_o, 32'hA5);
      wr(4'd9, 8'h07);
      chk("req_ch3", request_o, 32'h8);
      wr(4'd13, 8'h00);
      chk("mc_mask", mask_o, 32'hF);
      chk("mc_command", command_o, 32'h0);
      chk("mc_request", request_o, 32'h0);
      chk("mc_mode", mode_o, 32'h02D440);
      rd(4'd13);
      chk("mc_rd_zero", cpu_rdata, 32'h00);
      wr(4'd14, 8'h00);
      chk("clr_mask", mask_o, 32'h0);

      // eop forces TC at nonzero count on ch3
      wr(4'd7, 8'h10);
      wr(4'd7, 8'h00);
      upd(2'd3, 1'b1);
      chk("eop_tc", tc_o, 32'h8);
      chk("eop_mask", mask_o, 32'h8);
      rd(4'd7);
      chk("eop_cnt_lo", cpu_rdata, 32'h0F);
      rd(4'd7);

      // Single-mask clear of ch3 during its non-autoinit TC: set wins
      @(negedge clk);
      cpu_wr = 1'b1; cpu_addr = 4'd10; cpu_wdata = 8'h03;
      upd_valid = 1'b1; upd_ch = 2'd3; eop = 1'b1;
      @(negedge clk);
      cpu_wr = 1'b0; upd_valid = 1'b0; eop = 1'b0;
      chk("mskconf_mask", mask_o, 32'h8);
      chk("mskconf_tc", tc_o, 32'h8);
      rd(4'd7);
      chk("mskconf_cnt_lo", cpu_rdata, 32'h0E);

      // Asynchronous reset in the middle of a write and an update
      wr(4'd8, 8'h33);
      chk("pre_rst_command", command_o, 32'h33);
      @(negedge clk);
      cpu_wr = 1'b1; cpu_addr = 4'd9; cpu_wdata = 8'h07;
      upd_valid = 1'b1; upd_ch = 2'd1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mask", mask_o, 32'hF);
      chk("arst_command", command_o, 32'h0);
      chk("arst_request", request_o, 32'h0);
      chk("arst_mode", mode_o, 32'h0);
      chk("arst_rdata", cpu_rdata, 32'h0);
      chk("arst_tc", tc_o, 32'h0);
      chk("arst_addr", addr_o, 32'h0);
      @(negedge clk);
      cpu_wr = 1'b0; upd_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_request", request_o, 32'h0);
      chk("post_rst_addr", addr_o, 32'h0);
      chk("post_rst_tc", tc_o, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
